muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised iterative multiply/divide unit for the EX stage; successor to the single-mode shift-and-add multiplier. Executes MIPS MULT, MULTU, DIV and DIVU on WIDTH-bit operands at one bit per cycle with an internal adder, and owns the HI/LO register pair. Operands are captured at start, so the pipeline may change SrcA/SrcB freely while the unit is busy. A start/busy/done handshake and a flush input let the hazard unit stall and cancel operations.

## Interface
- WIDTH, 32, operand and HI/LO width (≥ 4)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  launch operation; accepted only when busy=0 and flush=0
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start
- a  in  WIDTH  multiplicand / dividend; sampled with start
- b  in  WIDTH  multiplier / divisor; sampled with start
- flush  in  1  abort the in-flight operation
- wr_hi, wr_lo  in  1 each  MTHI/MTLO write enables
- wdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse: hi/lo hold the new result
- div_by_zero  out  1  qualifies done: last DIV/DIVU had b=0
- hi, lo  out  WIDTH each  HI/LO registers

## Operation
- Reset (rst_n=0, asynchronous): hi=0, lo=0, busy=0, done=0, div_by_zero=0, FSM→IDLE. Reset mid-operation discards the operation.
- FSM: IDLE → CALC (exactly WIDTH cycles) → FIX (1 cycle) → IDLE.
  - start in IDLE → CALC. Latch op, sign flags, magnitudes |a|, |b|. Unsigned ops use raw values. Clear the iteration counter.
  - CALC → FIX when the counter reaches WIDTH−1.
  - FIX → IDLE always. Commits hi/lo, pulses done.
- Multiply: 2·WIDTH accumulator, shift-and-add on the LSB each CALC cycle, WIDTH+1-bit add. Signed: negate the 2·WIDTH product in FIX when sign(a)≠sign(b). hi=product[2W−1:W], lo=product[W−1:0].
- Divide: restoring division, one quotient bit per CALC cycle, WIDTH+1-bit subtract. lo=quotient, hi=remainder. Signed: quotient negated when signs differ; remainder takes the sign of the dividend.
- Signed overflow: DIV of most-negative by −1 gives lo=most-negative (wrap), hi=0. MULT of most-negative by most-negative is exact (hi=2^(W−2)).
- Divide by zero (b=0): full latency is still used. In FIX, lo=all ones, hi=a, div_by_zero=1. Any other completing operation clears div_by_zero.
- flush: from any state, FSM→IDLE on the next edge. No done pulse; hi, lo and div_by_zero unchanged. flush and start in the same cycle: start is ignored.
- start while busy=1: ignored. The in-flight operation is unaffected.
- wr_hi/wr_lo: write wdata on the edge when busy=0. Ignored while busy=1, including the FIX commit edge. Simultaneous wr_hi and wr_lo write both.

## Timing
- Cycle 0: start sampled high at its end edge.
- Cycles 1..WIDTH: CALC, busy=1.
- Cycle WIDTH+1: FIX, busy=1.
- Cycle WIDTH+2: busy=0, done=1, hi/lo show the result. A new start may be accepted in this cycle.
- Start-to-result latency is WIDTH+2 cycles (34 for WIDTH=32), independent of op and operand values.
- Throughput: one operation per WIDTH+2 cycles.
- done is registered and high for exactly one cycle. busy is registered.
- hi/lo change only on: the FIX edge, an accepted MTHI/MTLO edge, or reset.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → done in cycle 34, hi=0xFFFFFFFE, lo=0x00000001, div_by_zero=0.
- MULT a=−3, b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. Back-to-back: DIVU a=100, b=7 started in the done cycle → lo=14, hi=2 after 34 more cycles.
- DIV a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 → done with div_by_zero=1, lo=0xFFFFFFFF, hi=0x1234. A following MULTU clears div_by_zero.
- Flush and stall cases:
  - start MULT, change a/b every cycle, assert flush in cycle 10 → busy=0 in cycle 11, no done, hi/lo keep prior values.
  - start pulses and wr_hi while busy → ignored.
- Reset and width cases:
  - rst_n low in cycle 20 of an operation → hi=lo=0, busy=done=0 immediately, no done later.
  - WIDTH=8: MULT 0x80×0x80 → hi=0x40, lo=0x00, done in cycle 10.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one bit per cycle, WIDTH+2 cycles start-to-result.
// Operands are captured at start; start is ignored while busy, flush cancels silently.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   input  logic             wr_hi,
   input  logic             wr_lo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t             state, state_nxt;
   logic [CW-1:0]      cnt;
   logic               is_div, neg_q, neg_r, b_zero;
   logic [WIDTH-1:0]   mag_b, a_raw;
   logic [2*WIDTH-1:0] acc, acc_nxt;

   logic               accept, last;
   logic               sign_a, sign_b;
   logic [WIDTH-1:0]   mag_a_in, mag_b_in;

   logic [WIDTH:0]     add_sum, div_sh, div_sub;
   logic               div_ge;

   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;

   assign accept   = start && (state == IDLE) && !flush;
   assign last     = (cnt == CW'(WIDTH - 1));
   assign sign_a   = op[0] & a[WIDTH-1];
   assign sign_b   = op[0] & b[WIDTH-1];
   assign mag_a_in = sign_a ? -a : a;
   assign mag_b_in = sign_b ? -b : b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = CALC;
         CALC:    if (last) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (flush) state_nxt = IDLE;
   end

   // One iteration: multiply shifts the accumulator right adding the multiplicand on
   // the LSB; divide shifts left and keeps the partial remainder when it is >= divisor.
   always_comb begin
      add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
      div_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_sub = div_sh - {1'b0, mag_b};
      div_ge  = div_sh[WIDTH] | ~div_sub[WIDTH];
      if (is_div) begin
         if (div_ge) begin
            acc_nxt = {div_sub[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         end else begin
            acc_nxt = {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_nxt = {add_sum, acc[WIDTH-1:1]};
      end
   end

   always_comb begin
      prod = neg_q ? -acc : acc;
      quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      if (b_zero) begin
         res_hi = a_raw;
         res_lo = '1;
      end else if (is_div) begin
         res_hi = rem;
         res_lo = quo;
      end else begin
         res_hi = prod[2*WIDTH-1:WIDTH];
         res_lo = prod[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         is_div      <= 1'b0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         b_zero      <= 1'b0;
         mag_b       <= '0;
         a_raw       <= '0;
         acc         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= '0;
         lo          <= '0;
      end else begin
         busy <= (state_nxt != IDLE);
         done <= 1'b0;
         if (accept) begin
            is_div <= op[1];
            neg_q  <= sign_a ^ sign_b;
            neg_r  <= sign_a;
            b_zero <= op[1] && (b == '0);
            mag_b  <= mag_b_in;
            a_raw  <= a;
            acc    <= {{WIDTH{1'b0}}, mag_a_in};
            cnt    <= '0;
         end else if (state == CALC) begin
            acc <= acc_nxt;
            cnt <= cnt + CW'(1);
         end
         if (state == FIX && !flush) begin
            hi          <= res_hi;
            lo          <= res_lo;
            div_by_zero <= b_zero;
            done        <= 1'b1;
         end
         // MTHI/MTLO only land while idle, so they can never race the FIX commit.
         if (!busy) begin
            if (wr_hi) hi <= wdata;
            if (wr_lo) lo <= wdata;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH=32 plus one WIDTH=8 corner case.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start, flush, wr_hi, wr_lo;
   logic [1:0]  op;
   logic [31:0] a, b, wdata;
   logic        busy, done, div_by_zero;
   logic [31:0] hi, lo;

   logic        start8, flush8, wr_hi8, wr_lo8;
   logic [1:0]  op8;
   logic [7:0]  a8, b8, wdata8;
   logic        busy8, done8, dbz8;
   logic [7:0]  hi8, lo8;

   int n_cmp = 0;
   int n_err = 0;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
      .flush(flush), .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
      .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
   );

   muldiv_unit #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
      .flush(flush8), .wr_hi(wr_hi8), .wr_lo(wr_lo8), .wdata(wdata8),
      .busy(busy8), .done(done8), .div_by_zero(dbz8), .hi(hi8), .lo(lo8)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Launch at the current negedge (cycle 0), scramble a/b while busy, return in the done cycle.
   task automatic run32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input string tag);
      int cyc;
      op    = o;
      a     = x;
      b     = y;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc   = 1;
      while (done !== 1'b1 && cyc < 100) begin
         a = $urandom;
         b = $urandom;
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_latency"}, cyc, 34);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  cyc;
      bit  seen;

      rst_n = 1'b0;
      start = 1'b0; flush = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
      op = 2'b00; a = '0; b = '0; wdata = '0;
      start8 = 1'b0; flush8 = 1'b0; wr_hi8 = 1'b0; wr_lo8 = 1'b0;
      op8 = 2'b00; a8 = '0; b8 = '0; wdata8 = '0;
      repeat (2) @(negedge clk);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_dbz", div_by_zero, 0);
      rst_n = 1'b1;
      @(negedge clk);

      run32(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
      chk("multu_max_hi", hi, 32'hFFFF_FFFE);
      chk("multu_max_lo", lo, 32'h0000_0001);
      chk("multu_max_dbz", div_by_zero, 0);

      run32(2'b01, 32'hFFFF_FFFD, 32'd5, "mult_neg");
      chk("mult_neg_hi", hi, 32'hFFFF_FFFF);
      chk("mult_neg_lo", lo, 32'hFFFF_FFF1);

      run32(2'b10, 32'd100, 32'd7, "divu_b2b");
      chk("divu_b2b_lo", lo, 32'd14);
      chk("divu_b2b_hi", hi, 32'd2);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("divu_hold_lo", lo, 32'd14);

      run32(2'b11, 32'hFFFF_FFF9, 32'd2, "div_neg");
      chk("div_neg_lo", lo, 32'hFFFF_FFFD);
      chk("div_neg_hi", hi, 32'hFFFF_FFFF);

      run32(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      chk("div_ovf_lo", lo, 32'h8000_0000);
      chk("div_ovf_hi", hi, 32'h0);

      run32(2'b10, 32'h1234, 32'h0, "divu_zero");
      chk("divu_zero_dbz", div_by_zero, 1);
      chk("divu_zero_lo", lo, 32'hFFFF_FFFF);
      chk("divu_zero_hi", hi, 32'h1234);

      run32(2'b00, 32'd3, 32'd4, "multu_small");
      chk("dbz_cleared", div_by_zero, 0);
      chk("multu_small_lo", lo, 32'd12);
      chk("multu_small_hi", hi, 32'd0);

      wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hAAAA_5555;
      @(negedge clk);
      wr_hi = 1'b0; wr_lo = 1'b0;
      chk("mt_both_hi", hi, 32'hAAAA_5555);
      chk("mt_both_lo", lo, 32'hAAAA_5555);
      wr_lo = 1'b1; wdata = 32'h1234_5678;
      @(negedge clk);
      wr_lo = 1'b0;
      chk("mtlo_lo", lo, 32'h1234_5678);
      chk("mtlo_hi_kept", hi, 32'hAAAA_5555);

      // Flush in cycle 10 of a MULT.
      op = 2'b01; a = 32'd2; b = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc   = 1;
      while (cyc < 10) begin
         a = $urandom;
         b = $urandom;
         @(negedge clk);
         cyc++;
      end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_busy", busy, 0);
      seen = 1'b0;
      repeat (40) begin
         if (done) seen = 1'b1;
         @(negedge clk);
      end
      chk("flush_no_done", seen, 0);
      chk("flush_hi_kept", hi, 32'hAAAA_5555);
      chk("flush_lo_kept", lo, 32'h1234_5678);

      start = 1'b1; flush = 1'b1; op = 2'b00; a = 32'd5; b = 32'd5;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      chk("flush_start_busy", busy, 0);
      seen = 1'b0;
      repeat (40) begin
         if (done) seen = 1'b1;
         @(negedge clk);
      end
      chk("flush_start_no_done", seen, 0);

      // Stray start and MTHI/MTLO while busy, including in the FIX cycle.
      op = 2'b00; a = 32'd6; b = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc   = 1;
      while (done !== 1'b1 && cyc < 100) begin
         start = (cyc == 5);
         if (cyc == 5) begin
            op = 2'b11; a = 32'd1; b = 32'd0;
         end
         wr_hi = (cyc == 8) || (cyc == 33);
         wr_lo = (cyc == 33);
         wdata = 32'hDEAD_BEEF;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
      chk("busy_ign_latency", cyc, 34);
      chk("busy_ign_hi", hi, 32'd0);
      chk("busy_ign_lo", lo, 32'd42);
      chk("busy_ign_dbz", div_by_zero, 0);

      // WIDTH=8 signed corner: 0x80 * 0x80.
      op8 = 2'b01; a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      cyc    = 1;
      while (done8 !== 1'b1 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      chk("w8_latency", cyc, 10);
      chk("w8_hi", hi8, 8'h40);
      chk("w8_lo", lo8, 8'h00);

      // Asynchronous reset in cycle 20 of an operation.
      op = 2'b00; a = 32'd5; b = 32'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_hi", hi, 0);
      chk("arst_lo", lo, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen  = 1'b0;
      repeat (40) begin
         if (done) seen = 1'b1;
         @(negedge clk);
      end
      chk("arst_no_done", seen, 0);
      chk("arst_busy_after", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
